// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU-sharing controller: field widths, flag bit
// positions and FSM state encodings.
package alu_share_ctrl_pkg;

  localparam int OP_W   = 2;
  localparam int FLAG_W = 4;

  // Flag vector layout is {cout, overflow, zero, negative}.
  localparam int FLAG_COUT = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG  = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bus between the requesters/consumer (master) and the
// ALU-sharing controller (slave).
interface alu_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5
) ();
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]                          req_valid;
  logic [N_REQ-1:0]                          req_ready;
  logic [alu_share_ctrl_pkg::OP_W*N_REQ-1:0] req_op;
  logic [WIDTH*N_REQ-1:0]                    req_x;
  logic [WIDTH*N_REQ-1:0]                    req_y;

  logic                                      rsp_valid;
  logic                                      rsp_ready;
  logic [ID_W-1:0]                           rsp_id;
  logic [WIDTH-1:0]                          rsp_f;
  logic [alu_share_ctrl_pkg::FLAG_W-1:0]     rsp_flags;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_f, rsp_flags
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap and
// returns a one-hot grant plus its encoded index. The pointer is held by the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !gnt_any && req[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU among N_REQ requesters:
// round-robin grant, one-cycle execute, registered result held until accepted.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus,
  output logic [OP_W-1:0]   alu_s,
  output logic [WIDTH-1:0]  alu_x,
  output logic [WIDTH-1:0]  alu_y,
  input  logic [WIDTH-1:0]  alu_f,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  f_q, f_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              arb_en;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign arb_en = rst_n && (state_q == ST_IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_f     = f_q;
  assign bus.rsp_flags = flags_q;
  assign alu_s         = op_q;
  assign alu_x         = x_q;
  assign alu_y         = y_q;
  assign ops_done      = cnt_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    id_d    = id_q;
    f_d     = f_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              op_d = bus.req_op[i*OP_W +: OP_W];
              x_d  = bus.req_x[i*WIDTH +: WIDTH];
              y_d  = bus.req_y[i*WIDTH +: WIDTH];
            end
          end
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        f_d     = alu_f;
        flags_d = alu_flags;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      id_q    <= '0;
      f_q     <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      id_q    <= id_d;
      f_q     <= f_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
